video_pattern_gen: RTL

//  Parametrised video timing and test-pattern source; successor to the single-mode colour-bar generator.

---
 rtl/video_timing_pkg.sv | 33 +++
 rtl/video_pattern_pixel.sv | 39 +++
 rtl/video_pattern_gen.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/video_timing_pkg.sv
// Shared enums, timing presets and colour-bar palette for the video pattern generator.
package video_timing_pkg;
  typedef enum logic [1:0] {PAT_BARS = 2'd0, PAT_SOLID = 2'd1, PAT_RAMP = 2'd2, PAT_CHECKER = 2'd3} pattern_e;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_STOP = 2'd2} state_e;

  typedef struct packed {
    int unsigned h_active;
    int unsigned h_fp;
    int unsigned h_sync;
    int unsigned h_bp;
    int unsigned v_active;
    int unsigned v_fp;
    int unsigned v_sync;
    int unsigned v_bp;
  } timing_t;

  localparam timing_t TIMING_720P    = '{1280, 110, 40, 220, 720, 5, 5, 20};
  localparam timing_t TIMING_1080P   = '{1920, 88, 44, 148, 1080, 4, 5, 36};
  localparam timing_t TIMING_480P    = '{720, 16, 62, 60, 480, 9, 6, 30};
  localparam timing_t TIMING_800X600 = '{800, 40, 128, 88, 600, 1, 4, 23};

  // {R,G,B} on/off masks; each set channel expands to full scale
  localparam logic [2:0] BAR_WHITE   = 3'b111;
  localparam logic [2:0] BAR_YELLOW  = 3'b110;
  localparam logic [2:0] BAR_CYAN    = 3'b011;
  localparam logic [2:0] BAR_GREEN   = 3'b010;
  localparam logic [2:0] BAR_MAGENTA = 3'b101;
  localparam logic [2:0] BAR_RED     = 3'b100;
  localparam logic [2:0] BAR_BLUE    = 3'b001;
  localparam logic [2:0] BAR_BLACK   = 3'b000;
  localparam logic [7:0][2:0] BAR_MASK = {BAR_BLACK, BAR_BLUE, BAR_RED, BAR_MAGENTA,
                                          BAR_GREEN, BAR_CYAN, BAR_YELLOW, BAR_WHITE};
endpackage

// File: rtl/video_pattern_pixel.sv
// Combinational colour for one pixel position; one instance per lane.
module video_pattern_pixel
  import video_timing_pkg::*;
#(
  parameter int CW       = 8,
  parameter int H_ACTIVE = 1920,
  parameter int CHK_LOG2 = 6
) (
  input  logic [11:0]     px,
  input  logic [11:0]     y,
  input  pattern_e        pattern,
  input  logic [3*CW-1:0] solid,
  output logic [3*CW-1:0] rgb
);
  localparam int BAR_W = H_ACTIVE / 8;

  logic [2:0] bar_idx;
  logic [2:0] mask;
  logic       chk_on;
  logic       unused_y;

  assign unused_y = ^y;

  always_comb begin
    // threshold compare avoids a divider for non power-of-two bar widths
    bar_idx = '0;
    for (int i = 1; i < 8; i++)
      if (int'(px) >= i * BAR_W) bar_idx = 3'(i);
    mask   = BAR_MASK[bar_idx];
    chk_on = px[CHK_LOG2] ^ y[CHK_LOG2];
    rgb    = '0;
    unique case (pattern)
      PAT_BARS:  rgb = {{CW{mask[2]}}, {CW{mask[1]}}, {CW{mask[0]}}};
      PAT_SOLID: rgb = solid;
      PAT_RAMP:  rgb = {3{px[CW-1:0]}};
      default:   rgb = {3*CW{chk_on}};
    endcase
  end
endmodule

// File: rtl/video_pattern_gen.sv
// Video timing generator with PPC pixel lanes, selectable test patterns and frame-granular run/stop.
module video_pattern_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE = 1920,
  parameter int H_FP     = 88,
  parameter int H_SYNC   = 44,
  parameter int H_BP     = 148,
  parameter int V_ACTIVE = 1080,
  parameter int V_FP     = 4,
  parameter int V_SYNC   = 5,
  parameter int V_BP     = 36,
  parameter bit HS_POL   = 1'b1,
  parameter bit VS_POL   = 1'b1,
  parameter int PPC      = 1,
  parameter int CW       = 8,
  parameter int CHK_LOG2 = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [1:0]          pattern_sel,
  input  logic [3*CW-1:0]     solid_rgb,
  output logic                hs,
  output logic                vs,
  output logic                de,
  output logic [PPC*3*CW-1:0] rgb,
  output logic [11:0]         x,
  output logic [11:0]         y,
  output logic                sof,
  output logic [15:0]         frame_cnt
);
  localparam int HT = (H_FP + H_SYNC + H_BP + H_ACTIVE) / PPC;
  localparam int VT = V_FP + V_SYNC + V_BP + V_ACTIVE;
  localparam logic [11:0] H_LAST   = 12'(HT - 1);
  localparam logic [11:0] V_LAST   = 12'(VT - 1);
  localparam logic [11:0] HS_START = 12'(H_FP / PPC);
  localparam logic [11:0] HS_END   = 12'((H_FP + H_SYNC) / PPC);
  localparam logic [11:0] HA_START = 12'((H_FP + H_SYNC + H_BP) / PPC);
  localparam logic [11:0] VS_START = 12'(V_FP);
  localparam logic [11:0] VS_END   = 12'(V_FP + V_SYNC);
  localparam logic [11:0] VA_START = 12'(V_FP + V_SYNC + V_BP);
  localparam logic [11:0] PPC_W    = 12'(PPC);

  state_e state, state_nx;
  logic [11:0] hc, vc;
  logic        run, h_last, frame_end;
  pattern_e    pat_q;
  logic [3*CW-1:0] solid_q;

  assign run       = (state != ST_IDLE);
  assign h_last    = (hc == H_LAST);
  assign frame_end = h_last && (vc == V_LAST);

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: if (enable) state_nx = ST_RUN;
      ST_RUN:  if (!enable) state_nx = ST_STOP;
      ST_STOP: if (frame_end) state_nx = enable ? ST_RUN : ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // counters sit at the origin while idle so RUN always starts a fresh frame
  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hc <= '0;
      vc <= '0;
    end else if (h_last) begin
      hc <= '0;
      vc <= (vc == V_LAST) ? '0 : vc + 12'd1;
    end else begin
      hc <= hc + 12'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pat_q   <= PAT_BARS;
      solid_q <= '0;
    end else if (run && hc == '0 && vc == '0) begin
      pat_q   <= pattern_e'(pattern_sel);
      solid_q <= solid_rgb;
    end
  end

  logic hs_c, vs_c, de_c, sof_c;
  logic [11:0] ax, ay;
  logic [PPC-1:0][11:0]     lane_px;
  logic [PPC-1:0][3*CW-1:0] lane_rgb;

  assign hs_c  = (hc >= HS_START) && (hc < HS_END);
  assign vs_c  = (vc >= VS_START) && (vc < VS_END);
  assign de_c  = (hc >= HA_START) && (vc >= VA_START);
  assign sof_c = de_c && (hc == HA_START) && (vc == VA_START);
  assign ax    = (hc - HA_START) * PPC_W;
  assign ay    = vc - VA_START;

  for (genvar k = 0; k < PPC; k++) begin : g_lane
    assign lane_px[k] = ax + 12'(k);
    video_pattern_pixel #(.CW(CW), .H_ACTIVE(H_ACTIVE), .CHK_LOG2(CHK_LOG2)) u_pix (
      .px     (lane_px[k]),
      .y      (ay),
      .pattern(pat_q),
      .solid  (solid_q),
      .rgb    (lane_rgb[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      hs  <= ~HS_POL;
      vs  <= ~VS_POL;
      de  <= 1'b0;
      rgb <= '0;
      x   <= '0;
      y   <= '0;
      sof <= 1'b0;
    end else begin
      hs  <= hs_c ? HS_POL : ~HS_POL;
      vs  <= vs_c ? VS_POL : ~VS_POL;
      de  <= de_c;
      rgb <= de_c ? lane_rgb : '0;
      x   <= de_c ? ax : '0;
      y   <= de_c ? ay : '0;
      sof <= sof_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                frame_cnt <= '0;
    else if (run && sof_c)  frame_cnt <= frame_cnt + 16'd1;
  end
endmodule
